// File: rtl/ram_ch_arb_if.sv
// Channel-side bus of the buffer-RAM arbiter: per-channel requests in, select and grant out.
// The arbiter takes the master modport, the flash channels take the slave modport.
interface ram_ch_arb_if;
    logic [15:0] ch_req;
    logic [3:0]  ch_num;
    logic [15:0] ch_gnt;
    logic        gnt_vld;
    logic        busy;

    modport master (
        input  ch_req,
        output ch_num,
        output ch_gnt,
        output gnt_vld,
        output busy
    );

    modport slave (
        output ch_req,
        input  ch_num,
        input  ch_gnt,
        input  gnt_vld,
        input  busy
    );
endinterface

// File: rtl/ram_ch_arb.sv
// Round-robin arbiter sharing the buffer-RAM path among 16 flash channels, with bounded
// bursts and a one-cycle turnaround (ARB) on every channel change.
module ram_ch_arb #(
    parameter int unsigned MAX_BURST = 64
) (
    input  logic         clk,
    input  logic         rst,
    ram_ch_arb_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StGrant
    } state_e;

    localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

    state_e      r_state;
    state_e      w_state_d;
    logic [3:0]  r_last;
    logic [3:0]  w_last_d;
    logic [3:0]  r_ch_num;
    logic [3:0]  w_ch_num_d;
    logic [7:0]  r_burst_cnt;
    logic [7:0]  w_burst_cnt_d;
    logic [15:0] r_ch_gnt;
    logic [15:0] w_ch_gnt_d;
    logic        r_gnt_vld;
    logic        w_gnt_vld_d;
    logic        r_busy;
    logic        w_busy_d;

    logic [3:0]  w_idx;
    logic [3:0]  w_winner;
    logic        w_found;
    logic [15:0] w_own_mask;
    logic        w_own_req;
    logic        w_other_req;
    logic        w_any_req;
    logic        w_burst_end;

    // Scan from the channel after the last owner; the last owner is visited last (k == 16).
    always_comb begin
        w_found  = 1'b0;
        w_winner = 4'd0;
        w_idx    = r_last;
        for (int k = 1; k <= 16; k++) begin
            w_idx = r_last + 4'(k);
            if (!w_found && bus.ch_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_own_mask  = 16'(1) << r_ch_num;
    assign w_own_req   = bus.ch_req[r_ch_num];
    assign w_other_req = |(bus.ch_req & ~w_own_mask);
    assign w_any_req   = |bus.ch_req;
    assign w_burst_end = (r_burst_cnt == BurstLast);

    always_comb begin
        w_state_d     = r_state;
        w_last_d      = r_last;
        w_ch_num_d    = r_ch_num;
        w_burst_cnt_d = r_burst_cnt;
        w_ch_gnt_d    = '0;
        w_gnt_vld_d   = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_d = StArb;
                end
            end
            StArb: begin
                if (w_found) begin
                    w_state_d     = StGrant;
                    w_ch_num_d    = w_winner;
                    w_last_d      = w_winner;
                    w_burst_cnt_d = 8'd0;
                    w_ch_gnt_d    = 16'(1) << w_winner;
                    w_gnt_vld_d   = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StGrant: begin
                w_burst_cnt_d = r_burst_cnt + 8'd1;
                w_ch_gnt_d    = w_own_mask;
                w_gnt_vld_d   = 1'b1;
                if (!w_own_req) begin
                    w_state_d   = w_other_req ? StArb : StIdle;
                    w_ch_gnt_d  = '0;
                    w_gnt_vld_d = 1'b0;
                end else if (w_burst_end) begin
                    if (w_other_req) begin
                        w_state_d   = StArb;
                        w_ch_gnt_d  = '0;
                        w_gnt_vld_d = 1'b0;
                    end else begin
                        // Sole requester: start a fresh burst without a turnaround.
                        w_burst_cnt_d = 8'd0;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_last      <= 4'd15;
            r_ch_num    <= 4'd0;
            r_burst_cnt <= 8'd0;
            r_ch_gnt    <= '0;
            r_gnt_vld   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_last      <= w_last_d;
            r_ch_num    <= w_ch_num_d;
            r_burst_cnt <= w_burst_cnt_d;
            r_ch_gnt    <= w_ch_gnt_d;
            r_gnt_vld   <= w_gnt_vld_d;
            r_busy      <= w_busy_d;
        end
    end

    assign bus.ch_num  = r_ch_num;
    assign bus.ch_gnt  = r_ch_gnt;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.busy    = r_busy;

endmodule

// File: doc/ram_ch_arb.md
Name: ram_ch_arb

Overview:
Round-robin arbiter that shares the single buffer-RAM access path among the 16 flash channels.
It drives the 4-bit channel select feeding the RAM output-enable channel mux, and issues a one-hot grant back to the channels.
Bounded bursts prevent any channel from starving the others.
One turnaround cycle is inserted on every channel change so the mux select settles before a grant is asserted.

Parameters:
MAX_BURST, 64, max consecutive grant cycles for one channel while another channel is waiting; legal range 1..255.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
ch_req  input  16  per-channel request; bit i held high while channel i needs the RAM path
ch_num  output  4  selected channel index, driven to RAM channel mux select
ch_gnt  output  16  one-hot grant; bit ch_num high only while gnt_vld=1
gnt_vld  output  1  grant active; channel ch_num owns the RAM path this cycle
busy  output  1  high in ARB or GRANT state

Behaviour:
Reset values (asynchronous, immediate, also mid-operation):
- state=IDLE, ch_num=0, ch_gnt=0, gnt_vld=0, busy=0.
- Internal: last pointer=15, so channel 0 has top priority after reset; burst_cnt=0.

Storage and width rules:
- All outputs are registered.
- burst_cnt is 8 bits.

IDLE:
- gnt_vld=0, ch_gnt=0.
- If |ch_req at an edge → ARB.

ARB (exactly 1 cycle, turnaround):
- Winner = first i with ch_req[i]=1, scanning i=(last+1) mod 16 upward with wrap 15→0.
- If a winner exists at the edge:
  - ch_num←winner, last←winner, burst_cnt←0, ch_gnt←onehot(winner), gnt_vld←1 → GRANT.
- If no requests at the edge (all dropped) → IDLE; ch_num and last unchanged.
- gnt_vld=0 throughout ARB.

GRANT:
- gnt_vld=1, ch_gnt=onehot(ch_num); burst_cnt increments each cycle.
- Exit conditions, evaluated at each edge in priority order:
  1. ch_req[ch_num]=0 and any other req high → ARB.
  2. ch_req[ch_num]=0 and no req → IDLE.
  3. burst_cnt==MAX_BURST-1 and any other channel requesting → ARB (preemption).
  4. burst_cnt==MAX_BURST-1 and no other request → stay in GRANT, burst_cnt←0 (new burst, no turnaround).
  5. Otherwise stay in GRANT.
- On exit to ARB or IDLE: gnt_vld←0, ch_gnt←0 at that edge; ch_num holds its value.

Latency and throughput:
- Request seen at edge N in IDLE → ARB; gnt_vld=1 after edge N+1 (2-cycle latency).
- Handoff gap between consecutive grants is exactly 1 cycle (ARB).

Fairness:
- The releasing or preempted channel is lowest priority in the following ARB.
- It can win again only if it is the only requester at that ARB edge.

Simultaneous events:
- Requests arriving during GRANT are queued implicitly by level; channels must hold ch_req.
- A new request arriving in the same cycle as the owner's release is considered in that ARB cycle.
- MAX_BURST=1: preempt after every grant cycle whenever others are waiting.

Test Plan:
- Reset, then ch_req=16'h0001 held → ARB next cycle; then ch_num=0, ch_gnt=16'h0001, gnt_vld=1 two cycles after request.
- ch_req=16'h8421, each channel releases after 3 grant cycles → grant order 0,5,10,15; one gnt_vld=0 cycle between each; busy stays high.
- MAX_BURST=4, ch_req=16'h0003 held permanently → alternating grants 0,1,0,1; each 4 cycles long with 1 turnaround cycle.
- MAX_BURST=4, only ch_req[7] held → gnt_vld stays 1 continuously, ch_num=7, no turnaround cycles.
- In ARB, drop all requests in the same cycle → return to IDLE, gnt_vld never asserted, ch_num unchanged.
- Assert rst mid-GRANT on channel 9 → ch_gnt=0, gnt_vld=0, ch_num=0 immediately (asynchronous); after release with ch_req=16'h0201, channel 0 is granted first.
